// File: rtl/handshake_const_sink_check.sv
// rtl/handshake_const_sink_check.sv - constant-checking data sink with a two-entry elastic control-token output
// Every accepted token is compared against EXPECTED; one pure control token is returned per accepted input.
module handshake_const_sink_check #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] EXPECTED   = 32'h0000000A,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  ctrl_valid,
   input  logic                  ctrl_ready,
   output logic                  mismatch,
   output logic [CNT_WIDTH-1:0]  mismatch_count,
   output logic [CNT_WIDTH-1:0]  token_count
);

   localparam logic [DATA_WIDTH-1:0] EXP_C = DATA_WIDTH'(EXPECTED);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_t;

   state_t               state_q;
   logic                 acc;
   logic                 emit;
   logic                 bad;
   logic                 mismatch_q;
   logic                 mismatch_d;
   logic [CNT_WIDTH-1:0] mcount_q;
   logic [CNT_WIDTH-1:0] mcount_d;
   logic [CNT_WIDTH-1:0] tcount_q;
   logic [CNT_WIDTH-1:0] tcount_d;

   // Both handshake outputs decode the state register only, so ctrl_ready never reaches ins_ready.
   assign ins_ready  = (state_q != ST_TWO);
   assign ctrl_valid = (state_q != ST_EMPTY);

   assign acc  = ins_valid && ins_ready;
   assign emit = ctrl_valid && ctrl_ready;
   assign bad  = acc && (ins != EXP_C);

   always_comb begin
      mismatch_d = mismatch_q | bad;
      mcount_d   = mcount_q;
      tcount_d   = tcount_q;
      if (bad && (mcount_q != {CNT_WIDTH{1'b1}})) begin
         mcount_d = mcount_q + CNT_WIDTH'(1);
      end
      if (emit) begin
         tcount_d = tcount_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (acc) state_q <= ST_ONE;
            end
            ST_ONE: begin
               if (acc && !emit)      state_q <= ST_TWO;
               else if (emit && !acc) state_q <= ST_EMPTY;
            end
            ST_TWO: begin
               if (emit) state_q <= ST_ONE;
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mismatch_q <= 1'b0;
         mcount_q   <= '0;
         tcount_q   <= '0;
      end else begin
         mismatch_q <= mismatch_d;
         mcount_q   <= mcount_d;
         tcount_q   <= tcount_d;
      end
   end

   assign mismatch       = mismatch_q;
   assign mismatch_count = mcount_q;
   assign token_count    = tcount_q;

endmodule

// File: tb/tb_handshake_const_sink_check.sv
// tb/tb_handshake_const_sink_check.sv - self-checking bench for handshake_const_sink_check
module tb_handshake_const_sink_check;

   logic        clk;
   logic        rst;
   logic [31:0] ins_a, ins_b;
   logic        iv_a, iv_b, cr_a, cr_b;
   logic        rdy_a, vld_a, mm_a;
   logic        rdy_b, vld_b, mm_b;
   logic [3:0]  mc_a, tc_a;
   logic [1:0]  mc_b, tc_b;

   int   n_checks = 0;
   int   n_errors = 0;

   int   m_occ, m_mc, m_tc;
   logic m_mm;
   int   sb[$];
   int   acc_seq = 0;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        cr;
      logic        rdy;
      logic        vld;
      logic        mm;
      int          mc;
      int          tc;
   } vec_t;

   vec_t vecs[11];
   int   exp_mc_b[6];

   handshake_const_sink_check #(.DATA_WIDTH(32), .EXPECTED(32'h0000000A), .CNT_WIDTH(4)) dut_a (
      .clk(clk), .rst(rst), .ins(ins_a), .ins_valid(iv_a), .ins_ready(rdy_a),
      .ctrl_valid(vld_a), .ctrl_ready(cr_a), .mismatch(mm_a),
      .mismatch_count(mc_a), .token_count(tc_a)
   );

   handshake_const_sink_check #(.DATA_WIDTH(32), .EXPECTED(32'h0000000A), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .ins(ins_b), .ins_valid(iv_b), .ins_ready(rdy_b),
      .ctrl_valid(vld_b), .ctrl_ready(cr_b), .mismatch(mm_b),
      .mismatch_count(mc_b), .token_count(tc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_occ = 0;
      m_mm  = 1'b0;
      m_mc  = 0;
      m_tc  = 0;
      sb.delete();
   endtask

   // One cycle on dut_a: the model predicts acc/emit, the scoreboard pops on each real emit.
   task automatic step(input logic iv, input logic [31:0] d, input logic cr);
      logic acc_m, emit_m, emit_dut;
      iv_a     = iv;
      ins_a    = d;
      cr_a     = cr;
      acc_m    = iv && (m_occ < 2);
      emit_m   = cr && (m_occ > 0);
      emit_dut = vld_a && cr;
      if (acc_m) begin
         sb.push_back(acc_seq);
         acc_seq++;
         if (d !== 32'h0000000A) begin
            m_mm = 1'b1;
            if (m_mc < 15) m_mc++;
         end
      end
      if (emit_dut) begin
         chk("sb_emit_has_token", int'(sb.size() > 0), 1);
         if (sb.size() > 0) void'(sb.pop_front());
      end
      if (emit_m) m_tc = (m_tc + 1) % 16;
      m_occ = m_occ + int'(acc_m) - int'(emit_m);
      @(posedge clk);
      #1;
      chk("ins_ready", int'(rdy_a), int'(m_occ < 2));
      chk("ctrl_valid", int'(vld_a), int'(m_occ > 0));
      chk("mismatch", int'(mm_a), int'(m_mm));
      chk("mismatch_count", int'(mc_a), m_mc);
      chk("token_count", int'(tc_a), m_tc);
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      iv_a = 1'b0;
      cr_a = 1'b0;
      iv_b = 1'b0;
      cr_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ins_ready", int'(rdy_a), 1);
      chk("rst_ctrl_valid", int'(vld_a), 0);
      chk("rst_counts", int'({mm_a, mc_a, tc_a}), 0);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      rst   = 1'b0;
      ins_a = '0;
      ins_b = '0;
      iv_a  = 1'b0;
      iv_b  = 1'b0;
      cr_a  = 1'b0;
      cr_b  = 1'b1;

      //          iv    d           cr    rdy   vld   mm    mc tc
      vecs[0]  = '{1'b1, 32'h0000000A, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
      vecs[1]  = '{1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      vecs[2]  = '{1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      vecs[3]  = '{1'b1, 32'h00000005, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1};
      vecs[5]  = '{1'b1, 32'h0000000A, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2};
      vecs[6]  = '{1'b1, 32'h00000007, 1'b1, 1'b1, 1'b1, 1'b1, 1, 3};
      vecs[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4};
      vecs[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4};
      vecs[9]  = '{1'b1, 32'h0000000A, 1'b1, 1'b1, 1'b1, 1'b1, 1, 4};
      vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1, 5};
      exp_mc_b = '{1, 2, 3, 3, 3, 3};

      // Reset then back-to-back stream of matching tokens.
      do_reset();
      @(posedge clk);
      #1;
      chk("post_rst_ins_ready", int'(rdy_a), 1);
      chk("post_rst_ctrl_valid", int'(vld_a), 0);
      for (int i = 0; i < 10; i++) step(1'b1, 32'h0000000A, 1'b1);
      step(1'b0, 32'bx, 1'b1);
      chk("stream_token_count", int'(tc_a), 10);
      chk("stream_mismatch", int'(mm_a), 0);

      // Hand-derived vectors: backpressure fill, simultaneous acc/emit, ignored ins.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].cr);
         chk($sformatf("vec%0d_ready", i), int'(rdy_a), int'(vecs[i].rdy));
         chk($sformatf("vec%0d_valid", i), int'(vld_a), int'(vecs[i].vld));
         chk($sformatf("vec%0d_mismatch", i), int'(mm_a), int'(vecs[i].mm));
         chk($sformatf("vec%0d_mcount", i), int'(mc_a), vecs[i].mc);
         chk($sformatf("vec%0d_tcount", i), int'(tc_a), vecs[i].tc);
      end

      // 17 emits on the 4-bit token counter wraps to 1.
      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 32'h0000000A, 1'b1);
      step(1'b0, 32'bx, 1'b1);
      chk("wrap_token_count", int'(tc_a), 1);

      // Fill to TWO, then pulse reset between edges.
      step(1'b1, 32'h00000003, 1'b0);
      step(1'b1, 32'h0000000A, 1'b0);
      chk("full_ins_ready", int'(rdy_a), 0);
      #2 rst = 1'b0;
      #1;
      chk("async_ins_ready", int'(rdy_a), 1);
      chk("async_ctrl_valid", int'(vld_a), 0);
      chk("async_counts", int'({mm_a, mc_a, tc_a}), 0);
      #1 rst = 1'b1;
      model_reset();
      iv_a = 1'b0;
      cr_a = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 32'bx, 1'b1);

      // Randomised traffic against the model and scoreboard.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] d;
         d = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000000A;
         step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 3; i++) step(1'b0, 32'bx, 1'b1);
      chk("sb_drained", sb.size(), 0);

      // 2-bit mismatch counter saturates at 3; mismatch stays sticky.
      for (int i = 0; i < 6; i++) begin
         iv_b  = 1'b1;
         ins_b = (i < 5) ? 32'h00000005 : 32'h0000000A;
         cr_b  = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d_mismatch", i), int'(mm_b), 1);
         chk($sformatf("sat%0d_mcount", i), int'(mc_b), exp_mc_b[i]);
         chk($sformatf("sat%0d_ready", i), int'(rdy_b), 1);
      end
      iv_b = 1'b0;
      @(posedge clk);
      #1;
      chk("sat_token_count", int'(tc_b), 2);
      chk("sat_ctrl_valid", int'(vld_b), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
